// File: rtl/env_follower_if.sv
// Port bundle for env_follower: audio sample and control settings in, envelope/gate/trigger out.
// The fall coefficient is named rel because release is a reserved word in SystemVerilog.
interface env_follower_if #(
    parameter int BITS  = 16,
    parameter int HOLDW = 16
);
    logic signed [BITS-1:0]  sigIn;
    logic        [BITS-1:0]  attack;
    logic        [BITS-1:0]  rel;
    logic        [BITS-2:0]  thrOn;
    logic        [BITS-2:0]  thrOff;
    logic        [HOLDW-1:0] holdLen;
    logic signed [BITS-1:0]  envOut;
    logic                    gateOut;
    logic                    trigOut;

    modport master (
        output sigIn, attack, rel, thrOn, thrOff, holdLen,
        input  envOut, gateOut, trigOut
    );

    modport slave (
        input  sigIn, attack, rel, thrOn, thrOff, holdLen,
        output envOut, gateOut, trigOut
    );
endinterface

// File: rtl/env_follower.sv
// Envelope follower with gate/onset FSM: rectify, one-pole attack/release smoothing, hysteretic gate.
// Define ENV_FOLLOWER_HOLD_EN to add the HOLD state with its HOLDW-bit hold counter.
module env_follower #(
    parameter int BITS  = 16,
    parameter int HOLDW = 16
) (
    input  logic          clk,
    input  logic          rst,
    env_follower_if.slave bus
);
    localparam logic [BITS-1:0] MAXV = {1'b0, {(BITS-1){1'b1}}};
    localparam logic [BITS-1:0] MINV = {1'b1, {(BITS-1){1'b0}}};

    logic [BITS-1:0]        rect_d, rect_q, env_d, env;
    logic                   rise;
    logic [BITS:0]          d, step;
    logic [BITS-1:0]        coef;
    logic [2*BITS:0]        prod;
    logic signed [BITS+2:0] acc;

    // Most-negative input has no positive twin; pin it to full scale.
    always_comb begin
        if (!bus.sigIn[BITS-1])   rect_d = bus.sigIn;
        else if (bus.sigIn == MINV) rect_d = MAXV;
        else                      rect_d = $unsigned(-bus.sigIn);
    end

    always_comb begin
        rise = rect_q > env;
        d    = rise ? ({1'b0, rect_q} - {1'b0, env}) : ({1'b0, env} - {1'b0, rect_q});
        coef = rise ? bus.attack : bus.rel;
        prod = (2*BITS+1)'(d) * (2*BITS+1)'(coef);
        step = (BITS+1)'(prod >> BITS);
        // A truncated-to-zero step would stall short of the target forever.
        if (d != '0 && step == '0) step = (BITS+1)'(1);
        acc  = rise ? ($signed({3'b0, env}) + $signed({2'b0, step}))
                    : ($signed({3'b0, env}) - $signed({2'b0, step}));
        if (acc < 0)                           env_d = '0;
        else if (acc > $signed({3'b0, MAXV}))  env_d = MAXV;
        else                                   env_d = acc[BITS-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rect_q <= '0;
            env    <= '0;
        end else begin
            rect_q <= rect_d;
            env    <= env_d;
        end
    end

`ifdef ENV_FOLLOWER_HOLD_EN
    typedef enum logic [1:0] {IDLE, ATTACK, HOLD, RELEASE} state_t;
    logic [HOLDW-1:0] cnt, cnt_d;
`else
    typedef enum logic [1:0] {IDLE, ATTACK, RELEASE} state_t;
    logic unused_hold;
    assign unused_hold = ^bus.holdLen;
`endif

    state_t          state, state_d;
    logic            gate_q, gate_d, trig_q, trig_d;
    logic [BITS-1:0] on_x, off_x;

    // Hysteresis only makes sense with off below on; clamp a misconfigured off level.
    assign on_x  = {1'b0, bus.thrOn};
    assign off_x = (bus.thrOff < bus.thrOn) ? {1'b0, bus.thrOff} : on_x;

    always_comb begin
        state_d = state;
        trig_d  = 1'b0;
`ifdef ENV_FOLLOWER_HOLD_EN
        cnt_d   = cnt;
`endif
        case (state)
            IDLE: if (env >= on_x) begin
                state_d = ATTACK;
                trig_d  = 1'b1;
            end
            ATTACK: if (rect_q <= env) begin
`ifdef ENV_FOLLOWER_HOLD_EN
                state_d = HOLD;
                cnt_d   = bus.holdLen;
`else
                state_d = RELEASE;
`endif
            end
`ifdef ENV_FOLLOWER_HOLD_EN
            HOLD: if (cnt == '0) state_d = RELEASE;
                  else           cnt_d   = cnt - 1'b1;
`endif
            RELEASE: if (rect_q > env && rect_q >= on_x) begin
                state_d = ATTACK;
                trig_d  = 1'b1;
            end else if (env < off_x) begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        gate_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            gate_q <= 1'b0;
            trig_q <= 1'b0;
`ifdef ENV_FOLLOWER_HOLD_EN
            cnt    <= '0;
`endif
        end else begin
            state  <= state_d;
            gate_q <= gate_d;
            trig_q <= trig_d;
`ifdef ENV_FOLLOWER_HOLD_EN
            cnt    <= cnt_d;
`endif
        end
    end

    assign bus.envOut  = $signed(env);
    assign bus.gateOut = gate_q;
    assign bus.trigOut = trig_q;
endmodule
